// File: rtl/pbm_pkg.sv
// Shared types for the PicoBlaze-style port bus master: FSM encoding and command word layout.
// The ACK state exists only when PBM_IRQ_EN is defined.
package pbm_pkg;

  localparam int CMD_W = 17;

  typedef struct packed {
    logic       write;
    logic [7:0] port;
    logic [7:0] data;
  } pbm_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_GAP    = 3'd3
`ifdef PBM_IRQ_EN
    ,
    ST_ACK    = 3'd4
`endif
  } pbm_state_t;

  function automatic pbm_cmd_t pbm_make_cmd(input logic write, input logic [7:0] port,
                                            input logic [7:0] data);
    pbm_cmd_t c;
    c.write = write;
    c.port  = port;
    c.data  = data;
    return c;
  endfunction

endpackage

// File: rtl/pb_port_master_if.sv
// Command/response channel plus the kcpsm6-style I/O port bus, as seen by pb_port_master.
interface pb_port_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_port;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic       irq_taken;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_port, cmd_data, in_port, interrupt,
    output cmd_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, read_strobe, interrupt_ack, irq_taken, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_port, cmd_data, in_port, interrupt,
    input  cmd_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, read_strobe, interrupt_ack, irq_taken, busy
  );

endinterface

// File: rtl/pbm_cmd_fifo.sv
// Synchronous command FIFO with fall-through head: a push into an empty FIFO is visible
// (and poppable) in the same cycle, which gives the 2-cycle enqueue-to-strobe latency.
module pbm_cmd_fifo
  import pbm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     srst_n,
  input  logic     push,
  input  pbm_cmd_t push_data,
  output logic     full,
  input  logic     pop,
  output pbm_cmd_t head,
  output logic     head_valid,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  pbm_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        bypass;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Push and pop on an empty FIFO pass the word straight through without storing it.
  assign bypass     = empty && push && pop;
  assign wr_en      = push && !full && !bypass;
  assign rd_en      = pop && !empty;
  assign head_valid = !empty || push;
  assign head       = empty ? push_data : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/pb_port_master.sv
// PicoBlaze-style I/O port bus initiator with kcpsm6 timing (SETUP, one-cycle STROBE, GAP).
// Define PBM_IRQ_EN to service the level interrupt from IDLE with a one-cycle interrupt_ack.
module pb_port_master
  import pbm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                sysclk,
  input  logic                sysreset_n,
  pb_port_master_if.master    bus
);

  localparam logic [2:0] GAP_LAST = 3'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  pbm_state_t state_reg, state_next;
  logic [7:0] port_id_reg, port_id_next;
  logic [7:0] out_port_reg, out_port_next;
  logic       write_reg, write_next;
  logic [2:0] gap_cnt_reg, gap_cnt_next;
  logic [7:0] rsp_data_reg;
  logic       rsp_valid_reg;
  logic       dispatch;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       head_valid;
  pbm_cmd_t   head;
  pbm_cmd_t   push_cmd;
  logic       read_done;

  assign push_cmd = pbm_make_cmd(bus.cmd_write, bus.cmd_port, bus.cmd_data);

  pbm_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sysclk),
    .srst_n     (sysreset_n),
    .push       (bus.cmd_valid),
    .push_data  (push_cmd),
    .full       (fifo_full),
    .pop        (fifo_pop),
    .head       (head),
    .head_valid (head_valid),
    .empty      (fifo_empty)
  );

  // The IDLE decision also runs on the last cycle of STROBE/GAP/ACK, so back-to-back
  // transactions are spaced 2+GAP_CYCLES cycles without an extra idle cycle.
  always_comb begin
    state_next    = state_reg;
    port_id_next  = port_id_reg;
    out_port_next = out_port_reg;
    write_next    = write_reg;
    gap_cnt_next  = gap_cnt_reg;
    fifo_pop      = 1'b0;
    dispatch      = 1'b0;

    case (state_reg)
      ST_IDLE: dispatch = 1'b1;
      ST_SETUP: state_next = ST_STROBE;
      ST_STROBE: begin
        if (GAP_CYCLES == 0) begin
          dispatch = 1'b1;
        end else begin
          state_next   = ST_GAP;
          gap_cnt_next = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          dispatch = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 3'd1;
        end
      end
`ifdef PBM_IRQ_EN
      ST_ACK: begin
        if (GAP_CYCLES == 0) begin
          dispatch = 1'b1;
        end else begin
          state_next   = ST_GAP;
          gap_cnt_next = '0;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase

    if (dispatch) begin
      state_next = ST_IDLE;
`ifdef PBM_IRQ_EN
      if (bus.interrupt) begin
        state_next = ST_ACK;
      end else
`endif
      if (head_valid) begin
        fifo_pop      = 1'b1;
        port_id_next  = head.port;
        out_port_next = head.data;
        write_next    = head.write;
        state_next    = ST_SETUP;
      end
    end
  end

  assign read_done = (state_reg == ST_STROBE) && !write_reg;

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      state_reg     <= ST_IDLE;
      port_id_reg   <= '0;
      out_port_reg  <= '0;
      write_reg     <= 1'b0;
      gap_cnt_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      port_id_reg   <= port_id_next;
      out_port_reg  <= out_port_next;
      write_reg     <= write_next;
      gap_cnt_reg   <= gap_cnt_next;
      rsp_valid_reg <= read_done;
      if (read_done) begin
        rsp_data_reg <= bus.in_port;
      end
    end
  end

  assign bus.cmd_ready    = !fifo_full;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_data     = rsp_data_reg;
  assign bus.port_id      = port_id_reg;
  assign bus.out_port     = out_port_reg;
  assign bus.write_strobe = (state_reg == ST_STROBE) && write_reg;
  assign bus.read_strobe  = (state_reg == ST_STROBE) && !write_reg;
  assign bus.busy         = (state_reg != ST_IDLE) || !fifo_empty;

`ifdef PBM_IRQ_EN
  assign bus.interrupt_ack = (state_reg == ST_ACK);
  assign bus.irq_taken     = (state_reg == ST_ACK);
`else
  logic unused_interrupt;
  assign unused_interrupt  = bus.interrupt;
  assign bus.interrupt_ack = 1'b0;
  assign bus.irq_taken     = 1'b0;
`endif

endmodule
